// File: rtl/gpio_bridge_pkg.sv
// rtl/gpio_bridge_pkg.sv - shared FSM encoding, register offsets and AHB constants for the GPIO bridge
// Contents:
//   state_t       bridge FSM states
//   REG_*         register offsets within a group (HADDR[3:2])
//   HTRANS_*      AHB-Lite transfer types
//   HSIZE_*       AHB-Lite transfer sizes
//   merge_lanes   byte-lane merge of write data into a 32-bit shadow
package gpio_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_SEL  = 3'd2,
        ST_RD_SMP  = 3'd3,
        ST_RD_DONE = 3'd4
    } state_t;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_ENA  = 2'd1;
    localparam logic [1:0] REG_IN   = 2'd2;
    localparam logic [1:0] REG_RSVD = 2'd3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_val,
        input logic [31:0] wdata,
        input logic [3:0]  mask
    );
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/gpio_byte_mask.sv
// rtl/gpio_byte_mask.sv - combinational AHB byte-lane mask from HSIZE and low address bits
// Ports:
//   hsize  in  3  transfer size
//   addr   in  2  HADDR[1:0]
//   mask   out 4  active byte lanes (0 for unsupported sizes)
module gpio_byte_mask
    import gpio_bridge_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr,
    output logic [3:0] mask
);

    always_comb begin
        mask = 4'h0;
        case (hsize)
            HSIZE_BYTE: mask = 4'b0001 << addr;
            HSIZE_HALF: mask = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: mask = 4'hF;
            default:    mask = 4'h0;
        endcase
    end

endmodule

// File: rtl/gpio_ahb_bridge.sv
// rtl/gpio_ahb_bridge.sv - AHB-Lite slave holding per-group GPIO shadows and driving the selected group
// Parameters:
//   NGROUP      number of GPIO groups served (1..4)
// Ports:
//   clk, RSTn   clock (rising edge), asynchronous active-low reset
//   HSEL, HADDR[5:0], HTRANS[1:0], HWRITE, HSIZE[2:0], HWDATA[31:0], HREADY   AHB-Lite inputs
//   HREADYOUT, HRDATA[31:0], HRESP                                          AHB-Lite outputs
//   write_byte[3:0]  byte-lane mask during the write data phase, else 0
//   group_id[3:0]    currently selected GPIO group
//   o_ena, o_dat     output-enable / output-data shadows of the selected group
//   i_dat            registered pin sample of the selected group
module gpio_ahb_bridge
    import gpio_bridge_pkg::*;
#(
    parameter int NGROUP = 4
) (
    input  logic        clk,
    input  logic        RSTn,
    input  logic        HSEL,
    input  logic [5:0]  HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic [3:0]  write_byte,
    output logic [3:0]  group_id,
    output logic [31:0] o_ena,
    output logic [31:0] o_dat,
    input  logic [31:0] i_dat
);

    state_t      state, state_nxt;

    logic        rdy;
    logic        accept;
    logic        grp_ok_a;
    logic [1:0]  reg_a;
    logic [3:0]  mask_a;

    logic [1:0]  grp_q;
    logic [1:0]  reg_q;
    logic [3:0]  mask_q;
    logic        grp_ok_q;
    logic [1:0]  sel;

    logic [31:0] dat_sh [4];
    logic [31:0] ena_sh [4];

    gpio_byte_mask u_byte_mask (
        .hsize (HSIZE),
        .addr  (HADDR[1:0]),
        .mask  (mask_a)
    );

    // Only the IN-read wait states stall the bus; ready is a pure function
    // of state so that accept never depends on itself.
    assign rdy      = (state != ST_RD_SEL) && (state != ST_RD_SMP);
    assign accept   = HSEL && HREADY && rdy &&
                      ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

    // Groups beyond NGROUP decode as the reserved register.
    assign grp_ok_a = int'(HADDR[5:4]) < NGROUP;
    assign reg_a    = grp_ok_a ? HADDR[3:2] : REG_RSVD;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = ST_IDLE;
        HREADYOUT  = rdy;
        HRDATA     = 32'h0;
        write_byte = 4'h0;

        case (state)
            ST_RD_SEL: state_nxt = ST_RD_SMP;
            ST_RD_SMP: state_nxt = ST_RD_DONE;
            default: begin
                // IDLE and every final data-phase cycle dispatch the next
                // address phase directly, so back-to-back transfers pipeline.
                if (accept) begin
                    if (HWRITE) begin
                        state_nxt = ST_WR;
                    end else if (reg_a == REG_IN) begin
                        state_nxt = ST_RD_SEL;
                    end else begin
                        state_nxt = ST_RD_DONE;
                    end
                end
            end
        endcase

        if (state == ST_WR) begin
            write_byte = mask_q;
        end

        // Zero-wait reads of DATA/ENA/RSVD also complete through RD_DONE.
        if (state == ST_RD_DONE) begin
            case (reg_q)
                REG_DATA: HRDATA = dat_sh[grp_q];
                REG_ENA:  HRDATA = ena_sh[grp_q];
                REG_IN:   HRDATA = i_dat;
                default:  HRDATA = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            grp_q    <= 2'd0;
            reg_q    <= REG_RSVD;
            mask_q   <= 4'h0;
            grp_ok_q <= 1'b0;
            sel      <= 2'd0;
            for (int g = 0; g < 4; g++) begin
                dat_sh[g] <= 32'h0;
                ena_sh[g] <= 32'h0;
            end
        end else begin
            if (accept) begin
                grp_q    <= HADDR[5:4];
                reg_q    <= reg_a;
                mask_q   <= mask_a;
                grp_ok_q <= grp_ok_a;
            end

            // Out-of-range groups leave sel alone so o_dat/o_ena always
            // reflect a real group.
            if (state == ST_WR && grp_ok_q) begin
                sel <= grp_q;
                case (reg_q)
                    REG_DATA: dat_sh[grp_q] <= merge_lanes(dat_sh[grp_q], HWDATA, mask_q);
                    REG_ENA:  ena_sh[grp_q] <= merge_lanes(ena_sh[grp_q], HWDATA, mask_q);
                    default:  ;
                endcase
            end

            // Selecting the group one cycle ahead lets the port sample its
            // pins during RD_SMP.
            if (state == ST_RD_SEL) begin
                sel <= grp_q;
            end
        end
    end

    assign o_dat    = dat_sh[sel];
    assign o_ena    = ena_sh[sel];
    assign group_id = {2'b00, sel};
    assign HRESP    = 1'b0;

endmodule

// File: tb/tb_gpio_ahb_bridge.sv
// tb/tb_gpio_ahb_bridge.sv - scoreboard testbench for gpio_ahb_bridge
module tb_gpio_ahb_bridge;
    import gpio_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        RSTn;
    logic        HSEL;
    logic [5:0]  HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic [3:0]  write_byte;
    logic [3:0]  group_id;
    logic [31:0] o_ena;
    logic [31:0] o_dat;
    logic [31:0] i_dat = 32'h0;

    always #5 clk = ~clk;

    gpio_ahb_bridge #(.NGROUP(4)) dut (
        .clk        (clk),
        .RSTn       (RSTn),
        .HSEL       (HSEL),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HWDATA     (HWDATA),
        .HREADY     (HREADY),
        .HREADYOUT  (HREADYOUT),
        .HRDATA     (HRDATA),
        .HRESP      (HRESP),
        .write_byte (write_byte),
        .group_id   (group_id),
        .o_ena      (o_ena),
        .o_dat      (o_dat),
        .i_dat      (i_dat)
    );

    assign HREADY = HREADYOUT;

    // GPIO port: pins driven where enabled, external level elsewhere; sampled one cycle late.
    logic [31:0] ext [4];
    always @(posedge clk) begin
        i_dat <= (o_dat & o_ena) | (ext[group_id[1:0]] & ~o_ena);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        int          waits;
        string       tag;
    } rd_exp_t;

    rd_exp_t     rd_q [$];
    logic [3:0]  wr_q [$];
    logic [31:0] dat_m [4];
    logic [31:0] ena_m [4];

    function automatic logic [3:0] model_mask(input logic [2:0] size, input logic [1:0] a);
        case (size)
            3'd0:    return 4'b0001 << a;
            3'd1:    return a[1] ? 4'b1100 : 4'b0011;
            3'd2:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // Drives one address phase (caller sits just after a rising edge), waits for
    // acceptance, then drives its write data in the following cycle.
    task automatic xfer(input logic wr, input logic [5:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input string tag);
        logic [1:0] g;
        logic [1:0] rr;
        logic [3:0] m;
        logic       ok;
        rd_exp_t    e;
        g  = addr[5:4];
        rr = addr[3:2];
        m  = model_mask(size, addr[1:0]);
        if (wr) begin
            wr_q.push_back(m);
            if (rr == 2'd0) dat_m[g] = lane_merge(dat_m[g], wdata, m);
            else if (rr == 2'd1) ena_m[g] = lane_merge(ena_m[g], wdata, m);
        end else begin
            e.tag = tag;
            case (rr)
                2'd0:    begin e.data = dat_m[g]; e.waits = 0; end
                2'd1:    begin e.data = ena_m[g]; e.waits = 0; end
                2'd2:    begin e.data = (dat_m[g] & ena_m[g]) | (ext[g] & ~ena_m[g]); e.waits = 2; end
                default: begin e.data = 32'h0; e.waits = 0; end
            endcase
            rd_q.push_back(e);
        end
        HSEL   = 1'b1;
        HTRANS = HTRANS_NONSEQ;
        HWRITE = wr;
        HADDR  = addr;
        HSIZE  = size;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (HREADYOUT) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_accepted"}, 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        HWDATA = wdata;
        HSEL   = 1'b0;
        HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0;
    endtask

    task automatic idle(input int n);
        HSEL   = 1'b0;
        HTRANS = HTRANS_IDLE;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: tracks data phases and pops scoreboard entries as they complete.
    initial begin
        logic dp_rd;
        logic dp_wr;
        int   waits;
        rd_exp_t e;
        logic [3:0] wm;
        dp_rd = 1'b0;
        dp_wr = 1'b0;
        waits = 0;
        forever begin
            @(negedge clk);
            if (!RSTn) begin
                dp_rd = 1'b0;
                dp_wr = 1'b0;
                waits = 0;
            end else begin
                if ((dp_rd || dp_wr) && !HREADYOUT) waits++;
                if (dp_rd && HREADYOUT) begin
                    chk("rd_sb_nonempty", 32'(rd_q.size() != 0), 32'd1);
                    if (rd_q.size() != 0) begin
                        e = rd_q.pop_front();
                        chk({e.tag, "_data"}, HRDATA, e.data);
                        chk({e.tag, "_waits"}, 32'(waits), 32'(e.waits));
                    end
                end
                if (dp_wr && HREADYOUT) begin
                    chk("wr_sb_nonempty", 32'(wr_q.size() != 0), 32'd1);
                    if (wr_q.size() != 0) begin
                        wm = wr_q.pop_front();
                        chk("write_byte", 32'(write_byte), 32'(wm));
                    end
                end
                if (!dp_rd && !dp_wr) begin
                    chk("idle_hrdata", HRDATA, 32'h0);
                    chk("idle_wbyte", 32'(write_byte), 32'h0);
                    chk("idle_ready", 32'(HREADYOUT), 32'd1);
                    chk("idle_hresp", 32'(HRESP), 32'd0);
                end
                if (HREADYOUT) begin
                    dp_rd = HSEL && HTRANS[1] && !HWRITE;
                    dp_wr = HSEL && HTRANS[1] && HWRITE;
                    waits = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RSTn   = 1'b0;
        HSEL   = 1'b0;
        HADDR  = 6'h0;
        HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0;
        HSIZE  = HSIZE_WORD;
        HWDATA = 32'h0;
        for (int g = 0; g < 4; g++) begin
            ext[g]   = 32'h0;
            dat_m[g] = 32'h0;
            ena_m[g] = 32'h0;
        end

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(HREADYOUT), 32'd1);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_wbyte", 32'(write_byte), 32'h0);
        chk("rst_o_dat", o_dat, 32'h0);
        chk("rst_o_ena", o_ena, 32'h0);
        chk("rst_group", 32'(group_id), 32'h0);
        @(posedge clk);
        #1;
        RSTn = 1'b1;
        idle(1);

        // ENA g2 after reset: zero, zero waits
        xfer(1'b0, 6'h24, HSIZE_WORD, 32'h0, "rd_ena_g2");
        idle(2);
        chk("o_ena_after_rst", o_ena, 32'h0);

        // word writes to group 1
        xfer(1'b1, 6'h10, HSIZE_WORD, 32'hA5A5_0F0F, "wr_dat_g1");
        xfer(1'b1, 6'h14, HSIZE_WORD, 32'h0000_FFFF, "wr_ena_g1");
        idle(1);
        chk("g1_group_id", 32'(group_id), 32'd1);
        chk("g1_o_dat", o_dat, 32'hA5A5_0F0F);
        chk("g1_o_ena", o_ena, 32'h0000_FFFF);

        // byte write lane 2, then pipelined readback
        xfer(1'b1, 6'h12, HSIZE_BYTE, 32'h003C_0000, "wr_byte_g1");
        xfer(1'b0, 6'h10, HSIZE_WORD, 32'h0, "rd_dat_g1");
        idle(1);
        chk("g1_o_dat_byte", o_dat, 32'hA53C_0F0F);

        // halfword upper lanes, unsupported size ignored, write-then-read same register
        xfer(1'b1, 6'h22, HSIZE_HALF, 32'hBEEF_0000, "wr_half_g2");
        xfer(1'b1, 6'h20, 3'd3, 32'hFFFF_FFFF, "wr_sz3_g2");
        xfer(1'b0, 6'h20, HSIZE_WORD, 32'h0, "rd_dat_g2");
        xfer(1'b1, 6'h25, HSIZE_BYTE, 32'h0000_7700, "wr_b1_ena_g2");
        xfer(1'b0, 6'h24, HSIZE_WORD, 32'h0, "rd_ena_g2b");
        idle(1);

        // reserved register
        xfer(1'b1, 6'h0C, HSIZE_WORD, 32'hDEAD_BEEF, "wr_rsvd");
        xfer(1'b0, 6'h0C, HSIZE_WORD, 32'h0, "rd_rsvd");
        idle(1);

        // BUSY transfer must not write
        HSEL = 1'b1; HTRANS = HTRANS_BUSY; HWRITE = 1'b1; HADDR = 6'h10; HSIZE = HSIZE_WORD;
        @(posedge clk); #1;
        HWDATA = 32'h1111_1111;
        idle(1);
        xfer(1'b0, 6'h10, HSIZE_WORD, 32'h0, "rd_after_busy");
        idle(1);

        // IN read of group 3 with external pins
        ext[3] = 32'h1234_5678;
        xfer(1'b0, 6'h38, HSIZE_WORD, 32'h0, "rd_in_g3");
        idle(3);
        chk("g3_group_id", 32'(group_id), 32'd3);

        // drive g0 then immediately read its pins back
        ext[0] = 32'h5A5A_5A00;
        xfer(1'b1, 6'h00, HSIZE_WORD, 32'h0000_00FF, "wr_dat_g0");
        xfer(1'b1, 6'h04, HSIZE_WORD, 32'h0000_00FF, "wr_ena_g0");
        xfer(1'b0, 6'h08, HSIZE_WORD, 32'h0, "rd_in_g0");
        xfer(1'b0, 6'h14, HSIZE_WORD, 32'h0, "rd_ena_g1_pipe");
        idle(2);

        // reset during RD_SMP aborts the read
        ext[2] = 32'hCAFE_F00D;
        xfer(1'b0, 6'h28, HSIZE_WORD, 32'h0, "rd_in_g2_abort");
        @(posedge clk);
        #1;
        RSTn = 1'b0;
        #1;
        chk("abort_ready", 32'(HREADYOUT), 32'd1);
        chk("abort_hrdata", HRDATA, 32'h0);
        chk("abort_o_dat", o_dat, 32'h0);
        chk("abort_o_ena", o_ena, 32'h0);
        chk("abort_group", 32'(group_id), 32'h0);
        rd_q.delete();
        wr_q.delete();
        for (int g = 0; g < 4; g++) begin
            dat_m[g] = 32'h0;
            ena_m[g] = 32'h0;
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        RSTn = 1'b1;
        for (int g = 0; g < 4; g++) begin
            xfer(1'b0, {g[1:0], 4'h0}, HSIZE_WORD, 32'h0, "rd_dat_cleared");
            xfer(1'b0, {g[1:0], 4'h4}, HSIZE_WORD, 32'h0, "rd_ena_cleared");
        end
        idle(5);

        chk("rd_sb_left", 32'(rd_q.size()), 32'd0);
        chk("wr_sb_left", 32'(wr_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
